// File: rtl/csc_pkg.sv
// Shared definitions for the colour-space-converter frame control slice:
// FSM encoding, default counter width and converter fixed-point constants.
package csc_pkg;

    localparam int unsigned CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitFb = 2'd1,
        StActive = 2'd2
    } csc_state_e;

    // BT.601 luma weights in unsigned Q1.10
    localparam int unsigned CSC_FRAC_W = 10;
    localparam logic [CSC_FRAC_W:0] CSC_KR = 11'd306;
    localparam logic [CSC_FRAC_W:0] CSC_KG = 11'd601;
    localparam logic [CSC_FRAC_W:0] CSC_KB = 11'd117;

endpackage

// File: rtl/edge_det.sv
// Registered rise/fall detector: compares each input bit against its copy
// from the previous cycle.
module edge_det #(
    parameter int unsigned W = 1
) (
    input  logic         pixelclk,
    input  logic         rst,
    input  logic [W-1:0] sig,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] sig_q;

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/csc_frame_ctrl.sv
// Frame controller observing the CSC output timing: tracks pixel coordinates,
// gates an ROI enable, measures frame geometry and flags geometry errors.
module csc_frame_ctrl
    import csc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             pixelclk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_x_start,
    input  logic [CNT_W-1:0] cfg_x_end,
    input  logic [CNT_W-1:0] cfg_y_start,
    input  logic [CNT_W-1:0] cfg_y_end,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_roi_de,
    output logic             o_active,
    output logic             o_frame_start,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_height,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] XMax = '1;

    logic [1:0] rise, fall;
    logic       fb, de_rise, de_fall;

    edge_det #(
        .W(2)
    ) u_edge_det (
        .pixelclk(pixelclk),
        .rst     (rst),
        .sig     ({i_vsync, i_de}),
        .rise    (rise),
        .fall    (fall)
    );

    assign fb      = rise[1];
    assign de_rise = rise[0];
    assign de_fall = fall[0];

    logic unused_sig;
    assign unused_sig = ^{i_hsync, fall[1]};

    csc_state_e state_q, state_d;
    logic [CNT_W-1:0] x_q, y_q, width_ref_q;
    logic [CNT_W-1:0] pend_xs_q, pend_xe_q, pend_ys_q, pend_ye_q;
    logic [CNT_W-1:0] shd_xs_q, shd_xe_q, shd_ys_q, shd_ye_q;
    logic [CNT_W-1:0] x_cur, y_cur, line_len;
    logic             active, start_fb, done_fb, x_sat, err_set, roi_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (cfg_en) state_d = StWaitFb;
            StWaitFb: if (fb) state_d = StActive;
            StActive: if (fb && !cfg_en) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        active   = (state_q == StActive);
        start_fb = fb && ((state_q == StWaitFb) || (active && cfg_en));
        done_fb  = fb && active;

        // Coordinates of the pixel presented this cycle
        x_cur = x_q;
        if (fb || de_rise) begin
            x_cur = '0;
        end else if (x_q != XMax) begin
            x_cur = x_q + CNT_W'(1);
        end
        y_cur    = fb ? '0 : y_q;
        x_sat    = i_de && !fb && !de_rise && (x_q == XMax);
        line_len = x_q + CNT_W'(1);

        err_set = active && ((de_fall && (y_q != '0) && (line_len != width_ref_q)) ||
                             x_sat || (fb && i_de));

        roi_hit = active && i_de &&
                  (x_cur >= shd_xs_q) && (x_cur <= shd_xe_q) &&
                  (y_cur >= shd_ys_q) && (y_cur <= shd_ye_q);
    end

    assign o_active = active;

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            width_ref_q   <= '0;
            pend_xs_q     <= '0;
            pend_xe_q     <= '0;
            pend_ys_q     <= '0;
            pend_ye_q     <= '0;
            shd_xs_q      <= '0;
            shd_xe_q      <= '0;
            shd_ys_q      <= '0;
            shd_ye_q      <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_roi_de      <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_width       <= '0;
            o_height      <= '0;
            o_err         <= 1'b0;
        end else begin
            state_q <= state_d;

            if (i_de) x_q <= x_cur;
            if (fb) begin
                y_q <= '0;
            end else if (de_fall) begin
                y_q <= y_q + CNT_W'(1);
            end
            if (de_fall && !fb && (y_q == '0)) width_ref_q <= line_len;

            if (cfg_load) begin
                pend_xs_q <= cfg_x_start;
                pend_xe_q <= cfg_x_end;
                pend_ys_q <= cfg_y_start;
                pend_ye_q <= cfg_y_end;
            end
            // A load landing on the starting FB bypasses the pending stage
            if (start_fb) begin
                shd_xs_q <= cfg_load ? cfg_x_start : pend_xs_q;
                shd_xe_q <= cfg_load ? cfg_x_end   : pend_xe_q;
                shd_ys_q <= cfg_load ? cfg_y_start : pend_ys_q;
                shd_ye_q <= cfg_load ? cfg_y_end   : pend_ye_q;
            end

            if (!active) begin
                o_x <= '0;
                o_y <= '0;
            end else if (i_de) begin
                o_x <= x_cur;
                o_y <= y_cur;
            end
            o_roi_de      <= roi_hit;
            o_frame_start <= start_fb;
            o_frame_done  <= done_fb;

            if (done_fb) begin
                o_width  <= width_ref_q;
                o_height <= y_q + CNT_W'(de_fall);
            end

            if (err_set) begin
                o_err <= 1'b1;
            end else if (cfg_load) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Directed bench for csc_frame_ctrl: drives 8x4 frames with vsync pulses and
// checks coordinates, ROI gating, geometry, pulses and error behaviour.
module tb_csc_frame_ctrl;

    localparam int CW = 11;

    logic          pixelclk = 1'b0;
    logic          rst, cfg_en, cfg_load;
    logic [CW-1:0] cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_end;
    logic          i_hsync, i_vsync, i_de;
    logic [CW-1:0] o_x, o_y, o_width, o_height;
    logic          o_roi_de, o_active, o_frame_start, o_frame_done, o_err;

    int errors = 0;
    int checks = 0;
    int fs_cnt, fd_cnt, roi_cnt, roi_l1, roi_l2;
    int roi_x, roi_y;
    logic load_at_fb = 1'b0;

    csc_frame_ctrl #(
        .CNT_W(CW)
    ) dut (
        .pixelclk     (pixelclk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .cfg_load     (cfg_load),
        .cfg_x_start  (cfg_x_start),
        .cfg_x_end    (cfg_x_end),
        .cfg_y_start  (cfg_y_start),
        .cfg_y_end    (cfg_y_end),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_de         (i_de),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_roi_de     (o_roi_de),
        .o_active     (o_active),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_width      (o_width),
        .o_height     (o_height),
        .o_err        (o_err)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        fs_cnt = 0; fd_cnt = 0; roi_cnt = 0; roi_l1 = 0; roi_l2 = 0;
        roi_x = -1; roi_y = -1;
    endtask

    // One clock: apply inputs, sample registered outputs 1 time unit after the edge
    task automatic step(input logic vs, input logic de);
        i_vsync = vs;
        i_de    = de;
        i_hsync = ~de;
        @(posedge pixelclk);
        #1;
        if (o_frame_start) fs_cnt++;
        if (o_frame_done) fd_cnt++;
        if (o_roi_de) begin
            if (roi_cnt == 0) begin
                roi_x = int'(o_x);
                roi_y = int'(o_y);
            end
            roi_cnt++;
            if (o_y == 1) roi_l1++;
            if (o_y == 2) roi_l2++;
        end
    endtask

    task automatic line(input int len);
        repeat (len) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        cfg_load = load_at_fb;
        step(1'b1, 1'b0);
        cfg_load = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic frame(input int w, input int h);
        vs_pulse();
        for (int l = 0; l < h; l++) line(w);
    endtask

    task automatic set_roi(input int xs, input int xe, input int ys, input int ye);
        cfg_x_start = CW'(xs);
        cfg_x_end   = CW'(xe);
        cfg_y_start = CW'(ys);
        cfg_y_end   = CW'(ye);
    endtask

    task automatic load_roi(input int xs, input int xe, input int ys, input int ye);
        set_roi(xs, xe, ys, ye);
        cfg_load = 1'b1;
        step(1'b0, 1'b0);
        cfg_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_load = 1'b0;
        set_roi(0, 0, 0, 0);
        clr();
        repeat (3) step(1'b0, 1'b0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_roi", o_roi_de, 0);
        chk("rst_active", o_active, 0);
        chk("rst_fstart", o_frame_start, 0);
        chk("rst_fdone", o_frame_done, 0);
        chk("rst_width", o_width, 0);
        chk("rst_height", o_height, 0);
        chk("rst_err", o_err, 0);
        rst = 1'b0;

        // Basic frame, ROI x 2..5 y 1..2
        load_roi(2, 5, 1, 2);
        cfg_en = 1'b1;
        step(1'b0, 1'b0);
        chk("waitfb_active", o_active, 0);
        clr(); frame(8, 4);
        chk("f1_start", fs_cnt, 1);
        chk("f1_done", fd_cnt, 0);
        chk("f1_roi", roi_cnt, 8);
        chk("f1_roi_l1", roi_l1, 4);
        chk("f1_roi_l2", roi_l2, 4);
        chk("f1_active", o_active, 1);
        chk("f1_err", o_err, 0);
        clr(); frame(8, 4);
        chk("f2_start", fs_cnt, 1);
        chk("f2_done", fd_cnt, 1);
        chk("f2_roi", roi_cnt, 8);
        chk("f2_width", o_width, 8);
        chk("f2_height", o_height, 4);

        // Mid-frame load does not affect the running frame
        clr(); vs_pulse(); line(8);
        load_roi(0, 0, 0, 0);
        repeat (3) line(8);
        chk("f3_roi_old", roi_cnt, 8);
        clr(); frame(8, 4);
        chk("f4_roi_new", roi_cnt, 1);
        chk("f4_roi_x", roi_x, 0);
        chk("f4_roi_y", roi_y, 0);

        // Load coincident with FB applies to the frame it starts
        set_roi(2, 5, 1, 2);
        load_at_fb = 1'b1;
        clr(); frame(8, 4);
        load_at_fb = 1'b0;
        chk("f5_roi_bypass", roi_cnt, 8);

        // Short line 2
        clr(); vs_pulse(); line(8); line(8);
        chk("f6_err_before", o_err, 0);
        line(7);
        chk("f6_err_short", o_err, 1);
        line(8);
        clr(); frame(8, 4);
        chk("f7_done", fd_cnt, 1);
        chk("f7_width", o_width, 8);
        chk("f7_height", o_height, 4);
        chk("f7_err_sticky", o_err, 1);
        load_roi(2, 5, 1, 2);
        chk("load_clr_err", o_err, 0);

        // Empty ROI
        load_roi(6, 2, 1, 2);
        clr(); frame(8, 4);
        chk("empty_roi", roi_cnt, 0);
        chk("empty_err", o_err, 0);
        load_roi(2, 5, 1, 2);

        // vsync rising while de is high
        clr(); vs_pulse(); line(8);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("vsde_err", o_err, 1);
        chk("vsde_done", o_frame_done, 1);
        chk("vsde_start", o_frame_start, 1);
        chk("vsde_height", o_height, 1);
        chk("vsde_x0", o_x, 0);
        chk("vsde_y0", o_y, 0);
        step(1'b0, 1'b1);
        chk("vsde_x1", o_x, 1);
        repeat (3) step(1'b0, 1'b1);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        line(8); line(8);
        load_roi(2, 5, 1, 2);
        chk("vsde_clr", o_err, 0);

        // Disable mid-frame
        clr(); vs_pulse(); line(8);
        cfg_en = 1'b0;
        repeat (3) line(8);
        chk("dis_still_active", o_active, 1);
        clr(); vs_pulse();
        chk("dis_done", fd_cnt, 1);
        chk("dis_no_start", fs_cnt, 0);
        chk("dis_inactive", o_active, 0);
        line(8); line(8);
        chk("dis_roi", roi_cnt, 0);
        chk("dis_x", o_x, 0);

        // Reset mid-frame at x=3, y=1
        cfg_en = 1'b1;
        step(1'b0, 1'b0);
        clr(); vs_pulse(); line(8);
        repeat (4) step(1'b0, 1'b1);
        chk("pre_rst_x", o_x, 3);
        chk("pre_rst_y", o_y, 1);
        chk("pre_rst_roi", o_roi_de, 1);
        rst = 1'b1;
        clr();
        step(1'b0, 1'b1);
        chk("mrst_x", o_x, 0);
        chk("mrst_y", o_y, 0);
        chk("mrst_roi", o_roi_de, 0);
        chk("mrst_active", o_active, 0);
        chk("mrst_width", o_width, 0);
        chk("mrst_height", o_height, 0);
        step(1'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        line(8); line(8);
        chk("post_rst_wait", o_active, 0);
        vs_pulse();
        chk("post_rst_no_done", fd_cnt, 0);
        chk("post_rst_start", fs_cnt, 1);
        chk("post_rst_active", o_active, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
